// File: rtl/dpram_pkg.sv
// Shared constants, legal parameter strings and the byte-merge helper for dpram_be.
package dpram_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_DW     = 512;
  localparam int MAX_BW     = MAX_DW / BYTE_W;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  localparam string TYPE_REAL   = "REAL";
  localparam string TYPE_MAGIC  = "MAGIC";
  localparam string RDW_OLD     = "OLD";
  localparam string RDW_NEW     = "NEW";
  localparam string INIT_FILE_S = "FILE";
  localparam string INIT_ZERO   = "ZERO";

  typedef enum logic {
    FILL_IDLE,
    FILL_CLEAR
  } fill_state_e;

  // Callers widen to MAX_DW and truncate the result back to their own width.
  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] oldWord,
                                                 input logic [MAX_DW-1:0] newWord,
                                                 input logic [MAX_BW-1:0] be);
    logic [MAX_DW-1:0] res;
    res = oldWord;
    for (int i = 0; i < MAX_BW; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = newWord[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_be_rd_pipe.sv
// Per-port read pipeline: RD_LAT stages of data+valid, data held when no read completes.
module dpram_rd_pipe #(
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          vld_o
);

  logic [DW-1:0] s1Data_q;
  logic          s1Vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Data_q <= '0;
      s1Vld_q  <= 1'b0;
    end else begin
      s1Vld_q <= req_i;
      if (req_i) s1Data_q <= data_i;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] s2Data_q;
    logic          s2Vld_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s2Data_q <= '0;
        s2Vld_q  <= 1'b0;
      end else begin
        s2Vld_q <= s1Vld_q;
        if (s1Vld_q) s2Data_q <= s1Data_q;
      end
    end

    assign data_o = s2Data_q;
    assign vld_o  = s2Vld_q;
  end else begin : g_lat1
    assign data_o = s1Data_q;
    assign vld_o  = s1Vld_q;
  end

endmodule

// File: rtl/dpram_be.sv
// Dual-port single-clock RAM with byte enables, port-1-wins collisions, OLD/NEW
// cross-port read-during-write, REAL/MAGIC read modes and optional zero-fill after reset.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int    N         = 16,
  parameter int    DW        = 32,
  parameter string TYPE      = "REAL",
  parameter int    RD_LAT    = 1,
  parameter string RDW       = "OLD",
  parameter string INIT      = "FILE",
  parameter string INIT_FILE = "mem.txt",
  parameter int    AW        = $clog2(N),
  parameter int    BW        = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en0,
  input  logic          en1,
  input  logic          wen0,
  input  logic          wen1,
  input  logic [BW-1:0] be0,
  input  logic [BW-1:0] be1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic [DW-1:0] dout0,
  output logic [DW-1:0] dout1,
  output logic          vld0,
  output logic          vld1,
  output logic          busy
);

  if (DW % BYTE_W != 0 || DW > MAX_DW) begin : g_badDw
    $error("dpram_be: DW must be a multiple of 8 and at most MAX_DW");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_badLat
    $error("dpram_be: RD_LAT must be 1 or 2");
  end
  if (!(TYPE == TYPE_REAL || TYPE == TYPE_MAGIC)) begin : g_badType
    $error("dpram_be: TYPE must be REAL or MAGIC");
  end
  if (!(RDW == RDW_OLD || RDW == RDW_NEW)) begin : g_badRdw
    $error("dpram_be: RDW must be OLD or NEW");
  end
  if (!(INIT == INIT_FILE_S || INIT == INIT_ZERO)) begin : g_badInit
    $error("dpram_be: INIT must be FILE or ZERO");
  end

  logic [DW-1:0] mem [N];
  logic [AW-1:0] clearCnt;
  logic          wr0, wr1, rd0, rd1;
  logic [DW-1:0] wrWord0, wrWord1;

  assign wr0 = en0 & wen0 & ~busy;
  assign wr1 = en1 & wen1 & ~busy;
  assign rd0 = en0 & ~wen0 & ~busy;
  assign rd1 = en1 & ~wen1 & ~busy;

  // Port 1 merges on top of port 0's result when both hit one word, so port 1 wins per byte.
  assign wrWord0 = DW'(be_merge(MAX_DW'(mem[addr0]), MAX_DW'(din0), MAX_BW'(be0)));
  assign wrWord1 = DW'(be_merge(MAX_DW'((wr0 && addr0 == addr1) ? wrWord0 : mem[addr1]),
                                MAX_DW'(din1), MAX_BW'(be1)));

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clearCnt] <= '0;
    end else begin
      if (wr0) mem[addr0] <= wrWord0;
      if (wr1) mem[addr1] <= wrWord1;
    end
  end

  if (INIT == INIT_ZERO) begin : g_fill
    fill_state_e   state_q;
    logic [AW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= FILL_CLEAR;
        cnt_q   <= '0;
      end else if (state_q == FILL_CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == AW'(N - 1)) state_q <= FILL_IDLE;
      end
    end

    assign busy     = (state_q == FILL_CLEAR);
    assign clearCnt = cnt_q;
  end else begin : g_noFill
    assign busy     = 1'b0;
    assign clearCnt = '0;
  end

  if (TYPE == TYPE_MAGIC) begin : g_magic
    assign dout0 = mem[addr0];
    assign dout1 = mem[addr1];
    assign vld0  = rd0;
    assign vld1  = rd1;
  end else begin : g_real
    logic [DW-1:0] rdData0, rdData1;

    // A read can only collide with the other port's write, so forward that port's merged word.
    if (RDW == RDW_NEW) begin : g_new
      assign rdData0 = (wr1 && addr1 == addr0) ? wrWord1 : mem[addr0];
      assign rdData1 = (wr0 && addr0 == addr1) ? wrWord0 : mem[addr1];
    end else begin : g_old
      assign rdData0 = mem[addr0];
      assign rdData1 = mem[addr1];
    end

    dpram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe0 (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (rd0),
      .data_i (rdData0),
      .data_o (dout0),
      .vld_o  (vld0)
    );

    dpram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe1 (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (rd1),
      .data_i (rdData1),
      .data_o (dout1),
      .vld_o  (vld1)
    );
  end

endmodule
